debug_host_ctrl: RTL and testbench

- Host-side master for the processor core's debug port: the opposite end of the DBG_* interface.
- Accepts one command at a time from a host link (UART/JTAG bridge) over a valid/ready channel.
- Sequences halt, resume, instruction injection, register read/write and core reset on the debug signals.
- Returns exactly one response per command over a second valid/ready channel.

---
 rtl/debug_host_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_debug_host_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_host_ctrl.sv
// Host-side debug master: takes one host command at a time, sequences the core's
// DBG_* halt/exec/register/reset signals and returns exactly one response per command.
module debug_host_ctrl #(
  parameter int DRAIN_CYCLES = 5,
  parameter int EXEC_CYCLES  = 5,
  parameter int RST_CYCLES   = 4
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iCmdValid,
  output logic        oCmdReady,
  input  logic [2:0]  iCmdOp,
  input  logic [4:0]  iCmdAddr,
  input  logic [31:0] iCmdData,
  output logic        oRspValid,
  input  logic        iRspReady,
  output logic [31:0] oRspData,
  output logic        oRspErr,
  output logic        oHalted,
  output logic        oDbgnRst,
  output logic        oDbgHalt,
  output logic        oDbgExec,
  output logic        oDbgReqInit,
  output logic [31:0] oDbgIns,
  output logic        oDbgRegWrite,
  output logic [4:0]  oDbgRdAddr,
  output logic [31:0] oDbgRdValue,
  output logic [4:0]  oDbgRsAddr,
  input  logic [31:0] iDbgRsValue
);

  localparam logic [2:0] OP_NOP      = 3'd0;
  localparam logic [2:0] OP_HALT     = 3'd1;
  localparam logic [2:0] OP_RESUME   = 3'd2;
  localparam logic [2:0] OP_EXEC     = 3'd3;
  localparam logic [2:0] OP_RDREG    = 3'd4;
  localparam logic [2:0] OP_WRREG    = 3'd5;
  localparam logic [2:0] OP_RESET    = 3'd6;

  localparam int MAX_A = (DRAIN_CYCLES > EXEC_CYCLES) ? DRAIN_CYCLES : EXEC_CYCLES;
  localparam int MAX_C = (MAX_A > RST_CYCLES) ? MAX_A : RST_CYCLES;
  localparam int CW    = (MAX_C < 2) ? 1 : $clog2(MAX_C);

  typedef enum logic [2:0] {
    S_IDLE, S_DRAIN, S_EXEC, S_EXWAIT, S_RDREG, S_CORERST, S_RESP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      oCmdReady    <= 1'b1;
      oRspValid    <= 1'b0;
      oRspData     <= '0;
      oRspErr      <= 1'b0;
      oHalted      <= 1'b0;
      oDbgnRst     <= 1'b1;
      oDbgHalt     <= 1'b0;
      oDbgExec     <= 1'b0;
      oDbgReqInit  <= 1'b0;
      oDbgIns      <= '0;
      oDbgRegWrite <= 1'b0;
      oDbgRdAddr   <= '0;
      oDbgRdValue  <= '0;
      oDbgRsAddr   <= '0;
    end else begin
      // Strobes are single-cycle pulses; only the cycle that raises one keeps it high.
      oDbgExec     <= 1'b0;
      oDbgRegWrite <= 1'b0;
      oDbgReqInit  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (iCmdValid && oCmdReady) begin
            oCmdReady <= 1'b0;
            case (iCmdOp)
              OP_NOP: begin
                state     <= S_RESP;
                oRspValid <= 1'b1;
              end
              OP_HALT: begin
                if (!oHalted) begin
                  oDbgHalt <= 1'b1;
                  cnt      <= CW'(DRAIN_CYCLES - 1);
                  state    <= S_DRAIN;
                end else begin
                  state     <= S_RESP;
                  oRspValid <= 1'b1;
                end
              end
              OP_RESUME: begin
                oDbgHalt  <= 1'b0;
                oHalted   <= 1'b0;
                state     <= S_RESP;
                oRspValid <= 1'b1;
              end
              OP_EXEC: begin
                if (oHalted) begin
                  oDbgExec <= 1'b1;
                  oDbgIns  <= iCmdData;
                  state    <= S_EXEC;
                end else begin
                  oRspErr   <= 1'b1;
                  state     <= S_RESP;
                  oRspValid <= 1'b1;
                end
              end
              OP_RDREG: begin
                if (oHalted) begin
                  oDbgRsAddr <= iCmdAddr;
                  state      <= S_RDREG;
                end else begin
                  oRspErr   <= 1'b1;
                  state     <= S_RESP;
                  oRspValid <= 1'b1;
                end
              end
              OP_WRREG: begin
                if (oHalted) begin
                  oDbgRdAddr   <= iCmdAddr;
                  oDbgRdValue  <= iCmdData;
                  // x0 is hardwired: suppress the strobe but still answer cleanly.
                  oDbgRegWrite <= (iCmdAddr != 5'd0);
                end else begin
                  oRspErr <= 1'b1;
                end
                state     <= S_RESP;
                oRspValid <= 1'b1;
              end
              OP_RESET: begin
                oDbgnRst <= 1'b0;
                cnt      <= CW'(RST_CYCLES - 1);
                state    <= S_CORERST;
              end
              default: begin
                oRspErr   <= 1'b1;
                state     <= S_RESP;
                oRspValid <= 1'b1;
              end
            endcase
          end
        end
        S_DRAIN: begin
          if (cnt == '0) begin
            oHalted   <= 1'b1;
            state     <= S_RESP;
            oRspValid <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_EXEC: begin
          cnt   <= CW'(EXEC_CYCLES - 1);
          state <= S_EXWAIT;
        end
        S_EXWAIT: begin
          if (cnt == '0) begin
            state     <= S_RESP;
            oRspValid <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_RDREG: begin
          oRspData  <= iDbgRsValue;
          state     <= S_RESP;
          oRspValid <= 1'b1;
        end
        S_CORERST: begin
          if (cnt == '0) begin
            oDbgnRst    <= 1'b1;
            oDbgReqInit <= 1'b1;
            state       <= S_RESP;
            oRspValid   <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_RESP: begin
          if (iRspReady) begin
            oRspValid <= 1'b0;
            oRspErr   <= 1'b0;
            oRspData  <= '0;
            oCmdReady <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          oCmdReady <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_host_ctrl.sv
// Directed, table-driven bench for debug_host_ctrl with a small register-file model
// answering register reads.
module tb_debug_host_ctrl;

  logic        iClk;
  logic        iRst;
  logic        iCmdValid;
  logic        oCmdReady;
  logic [2:0]  iCmdOp;
  logic [4:0]  iCmdAddr;
  logic [31:0] iCmdData;
  logic        oRspValid;
  logic        iRspReady;
  logic [31:0] oRspData;
  logic        oRspErr;
  logic        oHalted;
  logic        oDbgnRst;
  logic        oDbgHalt;
  logic        oDbgExec;
  logic        oDbgReqInit;
  logic [31:0] oDbgIns;
  logic        oDbgRegWrite;
  logic [4:0]  oDbgRdAddr;
  logic [31:0] oDbgRdValue;
  logic [4:0]  oDbgRsAddr;
  logic [31:0] iDbgRsValue;

  debug_host_ctrl #(
    .DRAIN_CYCLES(4),
    .EXEC_CYCLES (5),
    .RST_CYCLES  (4)
  ) dut (
    .iClk        (iClk),
    .iRst        (iRst),
    .iCmdValid   (iCmdValid),
    .oCmdReady   (oCmdReady),
    .iCmdOp      (iCmdOp),
    .iCmdAddr    (iCmdAddr),
    .iCmdData    (iCmdData),
    .oRspValid   (oRspValid),
    .iRspReady   (iRspReady),
    .oRspData    (oRspData),
    .oRspErr     (oRspErr),
    .oHalted     (oHalted),
    .oDbgnRst    (oDbgnRst),
    .oDbgHalt    (oDbgHalt),
    .oDbgExec    (oDbgExec),
    .oDbgReqInit (oDbgReqInit),
    .oDbgIns     (oDbgIns),
    .oDbgRegWrite(oDbgRegWrite),
    .oDbgRdAddr  (oDbgRdAddr),
    .oDbgRdValue (oDbgRdValue),
    .oDbgRsAddr  (oDbgRsAddr),
    .iDbgRsValue (iDbgRsValue)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // Register-file model: x0 reads 0, x1 reads 5, others a recognisable pattern.
  logic [31:0] rf [32];
  initial begin
    for (int r = 0; r < 32; r++) rf[r] = 32'hA000_0000 + 32'(r);
    rf[0] = 32'd0;
    rf[1] = 32'd5;
  end
  assign iDbgRsValue = rf[oDbgRsAddr];

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  addr;
    logic [31:0] data;
    int          lat;
    logic [31:0] rdata;
    logic        err;
    logic        halted;
    logic        dbghalt;
    int          n_exec;
    int          n_wr;
    int          n_init;
    int          n_rst;
    logic [31:0] ins;
    logic [4:0]  rdaddr;
    logic [31:0] rdval;
    logic [4:0]  rsaddr;
  } vec_t;

  localparam int NV = 16;
  localparam logic [114:0] RST_VAL = {1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                                      1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0};

  vec_t vecs [NV];
  vec_t v;
  int   n_cmp;
  int   n_bad;
  int   lat, ne, nw, ni, nr, cnt_bad;
  logic h1;

  function automatic logic [114:0] outs();
    return {oCmdReady, oRspValid, oRspData, oRspErr, oHalted, oDbgnRst, oDbgHalt, oDbgExec,
            oDbgReqInit, oDbgIns, oDbgRegWrite, oDbgRdAddr, oDbgRdValue, oDbgRsAddr};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    // op, addr, data, lat, rdata, err, halted, dbghalt, exec, wr, init, rst, ins, rdaddr, rdval, rsaddr
    vecs[0]  = '{3'd0, 5'd0, 32'h0,         1, 32'h0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 32'h0,         5'd0, 32'h0,         5'd0};
    vecs[1]  = '{3'd2, 5'd0, 32'h0,         1, 32'h0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 32'h0,         5'd0, 32'h0,         5'd0};
    vecs[2]  = '{3'd3, 5'd0, 32'h1111_1111, 1, 32'h0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 32'h0,         5'd0, 32'h0,         5'd0};
    vecs[3]  = '{3'd4, 5'd7, 32'h0,         1, 32'h0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 32'h0,         5'd0, 32'h0,         5'd0};
    vecs[4]  = '{3'd5, 5'd3, 32'h2222_2222, 1, 32'h0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 32'h0,         5'd0, 32'h0,         5'd0};
    vecs[5]  = '{3'd7, 5'd9, 32'h3333_3333, 1, 32'h0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 32'h0,         5'd0, 32'h0,         5'd0};
    vecs[6]  = '{3'd1, 5'd0, 32'h0,         5, 32'h0, 1'b0, 1'b1, 1'b1, 0, 0, 0, 0, 32'h0,         5'd0, 32'h0,         5'd0};
    vecs[7]  = '{3'd1, 5'd0, 32'h0,         1, 32'h0, 1'b0, 1'b1, 1'b1, 0, 0, 0, 0, 32'h0,         5'd0, 32'h0,         5'd0};
    vecs[8]  = '{3'd3, 5'd0, 32'h0050_0093, 7, 32'h0, 1'b0, 1'b1, 1'b1, 1, 0, 0, 0, 32'h0050_0093, 5'd0, 32'h0,         5'd0};
    vecs[9]  = '{3'd4, 5'd1, 32'h0,         2, 32'h5, 1'b0, 1'b1, 1'b1, 0, 0, 0, 0, 32'h0050_0093, 5'd0, 32'h0,         5'd1};
    vecs[10] = '{3'd4, 5'd0, 32'h0,         2, 32'h0, 1'b0, 1'b1, 1'b1, 0, 0, 0, 0, 32'h0050_0093, 5'd0, 32'h0,         5'd0};
    vecs[11] = '{3'd5, 5'd3, 32'hDEAD_BEEF, 1, 32'h0, 1'b0, 1'b1, 1'b1, 0, 1, 0, 0, 32'h0050_0093, 5'd3, 32'hDEAD_BEEF, 5'd0};
    vecs[12] = '{3'd5, 5'd0, 32'h1234_5678, 1, 32'h0, 1'b0, 1'b1, 1'b1, 0, 0, 0, 0, 32'h0050_0093, 5'd0, 32'h1234_5678, 5'd0};
    vecs[13] = '{3'd6, 5'd0, 32'h0,         5, 32'h0, 1'b0, 1'b1, 1'b1, 0, 0, 1, 4, 32'h0050_0093, 5'd0, 32'h1234_5678, 5'd0};
    vecs[14] = '{3'd2, 5'd0, 32'h0,         1, 32'h0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 32'h0050_0093, 5'd0, 32'h1234_5678, 5'd0};
    vecs[15] = '{3'd6, 5'd0, 32'h0,         5, 32'h0, 1'b0, 1'b0, 1'b0, 0, 0, 1, 4, 32'h0050_0093, 5'd0, 32'h1234_5678, 5'd0};

    iRst      = 1'b0;
    iCmdValid = 1'b0;
    iCmdOp    = 3'd0;
    iCmdAddr  = 5'd0;
    iCmdData  = 32'd0;
    iRspReady = 1'b0;
    #2 iRst = 1'b1;
    #1 chk("reset_outputs", 128'(outs()), 128'(RST_VAL));
    tick();
    tick();
    iRst = 1'b0;
    tick();
    chk("idle_after_reset", 128'(outs()), 128'(RST_VAL));

    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      iCmdValid = 1'b1;
      iCmdOp    = v.op;
      iCmdAddr  = v.addr;
      iCmdData  = v.data;
      tick();
      iCmdValid = 1'b0;
      ne = 0; nw = 0; ni = 0; nr = 0; lat = 0;
      h1 = oDbgHalt;
      for (int k = 1; k <= 60; k++) begin
        ne += int'(oDbgExec);
        nw += int'(oDbgRegWrite);
        ni += int'(oDbgReqInit);
        nr += int'(!oDbgnRst);
        if (oRspValid) begin
          lat = k;
          break;
        end
        tick();
      end
      chk("rsp_latency", 128'(lat), 128'(v.lat));
      chk("rsp_data", 128'(oRspData), 128'(v.rdata));
      chk("rsp_err", 128'(oRspErr), 128'(v.err));
      chk("halted", 128'(oHalted), 128'(v.halted));
      chk("dbg_halt_first_cycle", 128'(h1), 128'(v.dbghalt));
      chk("dbg_halt_at_rsp", 128'(oDbgHalt), 128'(v.dbghalt));
      chk("dbg_buses", {oDbgIns, oDbgRdAddr, oDbgRdValue, oDbgRsAddr},
          {v.ins, v.rdaddr, v.rdval, v.rsaddr});
      chk("cmd_ready_busy", 128'(oCmdReady), 128'(1'b0));
      tick();
      ne += int'(oDbgExec);
      nw += int'(oDbgRegWrite);
      ni += int'(oDbgReqInit);
      nr += int'(!oDbgnRst);
      chk("rsp_hold", 128'({oRspValid, oRspErr, oRspData}), 128'({1'b1, v.err, v.rdata}));
      chk("exec_pulses", 128'(ne), 128'(v.n_exec));
      chk("regwrite_pulses", 128'(nw), 128'(v.n_wr));
      chk("reqinit_pulses", 128'(ni), 128'(v.n_init));
      chk("nrst_low_cycles", 128'(nr), 128'(v.n_rst));
      iRspReady = 1'b1;
      tick();
      iRspReady = 1'b0;
      chk("handshake", 128'({oRspValid, oCmdReady}), 128'(2'b01));
      $display("vec %0d op=%0d addr=%0d lat=%0d rdata=%h err=%b halted=%b",
               i, v.op, v.addr, lat, oRspData, v.err, oHalted);
    end

    // Response back-pressure: a reserved op held unacknowledged for 10 cycles.
    iCmdValid = 1'b1;
    iCmdOp    = 3'd7;
    tick();
    iCmdValid = 1'b0;
    cnt_bad = 0;
    for (int k = 0; k < 10; k++) begin
      if ({oRspValid, oRspErr, oRspData, oCmdReady} !== {1'b1, 1'b1, 32'd0, 1'b0}) cnt_bad++;
      tick();
    end
    chk("stall_stable_cycles_bad", 128'(cnt_bad), 128'(0));
    iRspReady = 1'b1;
    tick();
    iRspReady = 1'b0;
    chk("stall_release", 128'({oRspValid, oCmdReady}), 128'(2'b01));
    $display("stall op=7 held 10 cycles, bad_cycles=%0d", cnt_bad);

    // Reset asserted mid-drain must clear everything at once and drop the command.
    iCmdValid = 1'b1;
    iCmdOp    = 3'd1;
    tick();
    iCmdValid = 1'b0;
    tick();
    tick();
    chk("drain_in_progress", 128'({oDbgHalt, oRspValid}), 128'(2'b10));
    #2 iRst = 1'b1;
    #1 chk("async_reset_outputs", 128'(outs()), 128'(RST_VAL));
    tick();
    iRst = 1'b0;
    cnt_bad = 0;
    for (int k = 0; k < 10; k++) begin
      if (oRspValid !== 1'b0) cnt_bad++;
      tick();
    end
    chk("no_rsp_after_abort", 128'(cnt_bad), 128'(0));
    chk("idle_after_abort", 128'(outs()), 128'(RST_VAL));
    $display("abort halt by reset, spurious_rsp_cycles=%0d", cnt_bad);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
